// File: rtl/div_unit_pkg.sv
// Shared constants for the sequential divider: operand width, FSM encoding,
// HI/LO field positions and the signed-magnitude helper.
package div_unit_pkg;

    localparam int DIV_W  = 32;
    localparam int HI_LSB = 32;
    localparam int LO_LSB = 0;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ON      = 2'd1;
    localparam logic [1:0] ST_DIVZERO = 2'd2;
    localparam logic [1:0] ST_END     = 2'd3;

    // Two's-complement magnitude; -2^31 maps onto 0x80000000 without loss.
    function automatic logic [DIV_W-1:0] magnitude(input logic [DIV_W-1:0] value,
                                                   input logic             is_signed);
        return (is_signed && value[DIV_W-1]) ? (~value + 1'b1) : value;
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring radix-2 iteration: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference when it is non-negative.
module div_step
    import div_unit_pkg::*;
(
    input  logic [DIV_W:0]   rem_i,
    input  logic             dvd_bit_i,
    input  logic [DIV_W-1:0] divisor_i,
    output logic [DIV_W:0]   rem_o,
    output logic             q_bit_o
);

    logic [DIV_W+1:0] shifted;
    logic [DIV_W+1:0] trial;

    assign shifted = {rem_i, dvd_bit_i};
    assign trial   = shifted - {2'b00, divisor_i};

    // The trial difference is bounded by 2*divisor, so its msb is a clean sign bit.
    assign q_bit_o = ~trial[DIV_W+1];
    assign rem_o   = trial[DIV_W+1] ? shifted[DIV_W:0] : trial[DIV_W:0];

endmodule

// File: rtl/div_unit.sv
// Sequential 32-bit DIV/DIVU unit with start/ready handshake and flush annul;
// result is {remainder, quotient} in HI/LO layout.
module div_unit
    import div_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 div_sign,
    input  logic                 div_start_i,
    input  logic                 div_annul_i,
    input  logic [DIV_W-1:0]     div_op1,
    input  logic [DIV_W-1:0]     div_op2,
    output logic [2*DIV_W-1:0]   result,
    output logic                 div_ready_o,
    output logic                 div_busy_o
);

    logic [1:0]           state_q,    state_d;
    logic [4:0]           count_q,    count_d;
    logic [DIV_W:0]       rem_q,      rem_d;
    logic [DIV_W-1:0]     dvd_q,      dvd_d;
    logic [DIV_W-1:0]     dvs_q,      dvs_d;
    logic                 neg_quo_q,  neg_quo_d;
    logic                 neg_rem_q,  neg_rem_d;
    logic [2*DIV_W-1:0]   result_q,   result_d;

    logic [DIV_W:0]       step_rem;
    logic                 step_q_bit;
    logic [DIV_W-1:0]     quo_raw;
    logic [DIV_W-1:0]     quo_fix;
    logic [DIV_W-1:0]     rem_fix;

    div_step u_step (
        .rem_i     (rem_q),
        .dvd_bit_i (dvd_q[DIV_W-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q_bit)
    );

    // The dividend register doubles as the quotient: bits shift out the top
    // while quotient bits shift in at the bottom.
    assign quo_raw = {dvd_q[DIV_W-2:0], step_q_bit};
    assign quo_fix = neg_quo_q ? (~quo_raw + 1'b1) : quo_raw;
    assign rem_fix = neg_rem_q ? (~step_rem[DIV_W-1:0] + 1'b1) : step_rem[DIV_W-1:0];

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        case (state_q)
            ST_IDLE: begin
                if (div_start_i && !div_annul_i) begin
                    count_d   = '0;
                    rem_d     = '0;
                    neg_quo_d = div_sign & (div_op1[DIV_W-1] ^ div_op2[DIV_W-1]);
                    neg_rem_d = div_sign & div_op1[DIV_W-1];
                    dvs_d     = magnitude(div_op2, div_sign);
                    if (div_op2 == '0) begin
                        dvd_d   = div_op1;
                        state_d = ST_DIVZERO;
                    end else begin
                        dvd_d   = magnitude(div_op1, div_sign);
                        state_d = ST_ON;
                    end
                end
            end
            ST_ON: begin
                if (div_annul_i) begin
                    state_d = ST_IDLE;
                end else begin
                    rem_d   = step_rem;
                    dvd_d   = quo_raw;
                    count_d = count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        state_d                      = ST_END;
                        result_d[HI_LSB +: DIV_W]    = rem_fix;
                        result_d[LO_LSB +: DIV_W]    = quo_fix;
                    end
                end
            end
            ST_DIVZERO: begin
                if (div_annul_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d                   = ST_END;
                    result_d[HI_LSB +: DIV_W] = dvd_q;
                    result_d[LO_LSB +: DIV_W] = {DIV_W{1'b1}};
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    // A flush landing in the END cycle suppresses the pulse as well.
    assign result      = result_q;
    assign div_ready_o = (state_q == ST_END) && !div_annul_i;
    assign div_busy_o  = (state_q == ST_ON) || (state_q == ST_DIVZERO);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, randomized operations
// against a 64-bit arithmetic reference, plus annul/restart/reset sequences.
module tb_div_unit;

    logic        clk;
    logic        resetn;
    logic        div_sign;
    logic        div_start_i;
    logic        div_annul_i;
    logic [31:0] div_op1;
    logic [31:0] div_op2;
    logic [63:0] result;
    logic        div_ready_o;
    logic        div_busy_o;

    int total = 0;
    int bad   = 0;

    div_unit dut (
        .clk         (clk),
        .resetn      (resetn),
        .div_sign    (div_sign),
        .div_start_i (div_start_i),
        .div_annul_i (div_annul_i),
        .div_op1     (div_op1),
        .div_op2     (div_op2),
        .result      (result),
        .div_ready_o (div_ready_o),
        .div_busy_o  (div_busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero and
    // the remainder follows the dividend, matching DIV semantics.
    function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] qq, rr;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q  = sa / sb;
        r  = sa % sb;
        qq = q[31:0];
        rr = r[31:0];
        return {rr, qq};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; drives one start pulse, then watches up to 40 cycles.
    // Returns at the negedge one cycle after the ready pulse (or at the budget).
    task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                 output int lat, output int busy_cycles, output int ready_count);
        div_sign    = sgn;
        div_op1     = a;
        div_op2     = b;
        div_start_i = 1'b1;
        @(posedge clk);
        #1;
        div_start_i = 1'b0;
        lat         = -1;
        busy_cycles = 0;
        ready_count = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (div_busy_o) busy_cycles++;
            if (div_ready_o) begin
                ready_count++;
                if (lat < 0) lat = k;
            end
            if (lat >= 0 && k > lat) break;
        end
    endtask

    vec_t vecs[11];
    int   lat, busy_cycles, ready_count;
    logic [63:0] prev;

    initial begin
        resetn      = 1'b0;
        div_sign    = 1'b0;
        div_start_i = 1'b0;
        div_annul_i = 1'b0;
        div_op1     = '0;
        div_op2     = '0;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'h0000_000E, 32'h0000_0002};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'h0000_0001};
        vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 32'h0000_0000};
        vecs[4]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF, 32'h0000_0000};
        vecs[5]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF, 32'h0000_0005};
        vecs[6]  = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF, 32'h0000_0005};
        vecs[7]  = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF, 32'hFFFF_FFF9};
        vecs[8]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000};
        vecs[9]  = '{1'b0, 32'd3,          32'd10,         32'h0000_0000, 32'h0000_0003};
        vecs[10] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'h0000_0003, 32'hFFFF_FFFF};

        repeat (2) @(negedge clk);
        checkOutput("reset_result", result, 64'd0);
        checkOutput("reset_ready", {63'd0, div_ready_o}, 64'd0);
        checkOutput("reset_busy", {63'd0, div_busy_o}, 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, lat, busy_cycles, ready_count);
            checkOutput($sformatf("vec%0d_result", i), result, {vecs[i].r, vecs[i].q});
            checkOutput($sformatf("vec%0d_latency", i), 64'(lat), (vecs[i].b == 0) ? 64'd2 : 64'd33);
            checkOutput($sformatf("vec%0d_busy", i), 64'(busy_cycles), (vecs[i].b == 0) ? 64'd1 : 64'd32);
            checkOutput($sformatf("vec%0d_readycnt", i), 64'(ready_count), 64'd1);
        end

        for (int i = 0; i < 60; i++) begin
            logic        s;
            logic [31:0] a, b;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'($urandom_range(1, 255));
                1:       b = 32'd0;
                2:       b = -32'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            applyStimulus(s, a, b, lat, busy_cycles, ready_count);
            checkOutput($sformatf("rand%0d_result", i), result, refDiv(s, a, b));
            checkOutput($sformatf("rand%0d_latency", i), 64'(lat), (b == 0) ? 64'd2 : 64'd33);
        end

        // Annul at cycle 10 of an operation, then an immediate restart.
        applyStimulus(1'b0, 32'd100, 32'd7, lat, busy_cycles, ready_count);
        prev        = result;
        div_sign    = 1'b0;
        div_op1     = 32'd1000;
        div_op2     = 32'd3;
        div_start_i = 1'b1;
        @(posedge clk);
        #1;
        div_start_i = 1'b0;
        ready_count = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (div_ready_o) ready_count++;
        end
        div_annul_i = 1'b1;
        @(posedge clk);
        #1;
        div_annul_i = 1'b0;
        @(negedge clk);
        checkOutput("annul_busy", {63'd0, div_busy_o}, 64'd0);
        checkOutput("annul_ready", {63'd0, div_ready_o}, 64'd0);
        checkOutput("annul_result", result, prev);
        applyStimulus(1'b1, 32'hFFFF_FF9C, 32'd7, lat, busy_cycles, ready_count);
        checkOutput("restart_result", result, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
        checkOutput("restart_latency", 64'(lat), 64'd33);

        // A start pulse mid-operation must be ignored entirely.
        div_sign    = 1'b0;
        div_op1     = 32'd100;
        div_op2     = 32'd7;
        div_start_i = 1'b1;
        @(posedge clk);
        #1;
        div_start_i = 1'b0;
        ready_count = 0;
        lat         = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (div_ready_o) begin
                ready_count++;
                if (lat < 0) lat = k;
            end
            if (k == 5) begin
                div_sign    = 1'b1;
                div_op1     = 32'd50;
                div_op2     = 32'd5;
                div_start_i = 1'b1;
            end else if (k == 6) begin
                div_start_i = 1'b0;
            end
        end
        checkOutput("ignstart_readycnt", 64'(ready_count), 64'd1);
        checkOutput("ignstart_latency", 64'(lat), 64'd33);
        checkOutput("ignstart_result", result, {32'd2, 32'd14});

        // Start and annul together in IDLE: the start is dropped.
        prev        = result;
        div_op1     = 32'd9;
        div_op2     = 32'd0;
        div_start_i = 1'b1;
        div_annul_i = 1'b1;
        @(posedge clk);
        #1;
        div_start_i = 1'b0;
        div_annul_i = 1'b0;
        busy_cycles = 0;
        ready_count = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (div_busy_o) busy_cycles++;
            if (div_ready_o) ready_count++;
        end
        checkOutput("startannul_busy", 64'(busy_cycles), 64'd0);
        checkOutput("startannul_ready", 64'(ready_count), 64'd0);
        checkOutput("startannul_result", result, prev);

        // Asynchronous reset in the middle of an operation.
        div_sign    = 1'b0;
        div_op1     = 32'd200;
        div_op2     = 32'd9;
        div_start_i = 1'b1;
        @(posedge clk);
        #1;
        div_start_i = 1'b0;
        repeat (8) @(negedge clk);
        resetn = 1'b0;
        #1;
        checkOutput("asyncrst_result", result, 64'd0);
        checkOutput("asyncrst_ready", {63'd0, div_ready_o}, 64'd0);
        checkOutput("asyncrst_busy", {63'd0, div_busy_o}, 64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 32'd100, 32'd7, lat, busy_cycles, ready_count);
        checkOutput("postrst_result", result, {32'd2, 32'd14});
        checkOutput("postrst_latency", 64'(lat), 64'd33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
